// File: rtl/thermo_pkg.sv
// Shared constants, FSM encoding and the frame-to-degC clamp for the temperature sampler.
// Latency: n/a (package only).
// Backpressure: n/a.
package thermo_pkg;

    localparam int          TEMP_MAX    = 99;
    localparam int          FRAME_BITS  = 16;
    localparam logic [15:0] FAULT_FRAME = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_PROCESS,
        ST_UPDATE
    } state_e;

    // frame[15:4] is signed 1/16 degC; shifting that right by 4 arithmetically
    // leaves exactly frame[15:8] as a signed whole-degree value (floor).
    function automatic logic [6:0] clamp_deg(input logic [7:0] frame_hi);
        logic signed [7:0] deg;
        deg = $signed(frame_hi);
        if (deg < 8'sd0) begin
            clamp_deg = 7'd0;
        end else if (deg > 8'(TEMP_MAX)) begin
            clamp_deg = 7'(TEMP_MAX);
        end else begin
            clamp_deg = deg[6:0];
        end
    endfunction

endpackage

// File: rtl/sensor_spi_rx.sv
// SPI mode-0 receiver: generates sclk and shifts in 16 bits MSB first.
// Latency: done pulses 1+32*CLK_DIV cycles after start (registered, same edge as the 16th sclk fall).
// Backpressure: none; start is ignored while a frame is in flight.
// Ports: clk, rst (async active-low), start_i, miso_i -> sclk_o, done_o, frame_o.
module sensor_spi_rx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        done_o,
    output logic [15:0] frame_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy_q;
    logic             sclk_q;
    logic             done_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       fall_cnt_q;
    logic [15:0]      shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= '0;
            fall_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    busy_q     <= 1'b1;
                    sclk_q     <= 1'b0;
                    div_q      <= '0;
                    fall_cnt_q <= '0;
                end
            end else if (div_q == DIV_LAST) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
                if (!sclk_q) begin
                    // Rising edge: capture the bit the sensor set up on the previous fall.
                    shift_q <= {shift_q[14:0], miso_i};
                end else begin
                    fall_cnt_q <= fall_cnt_q + 4'd1;
                    if (fall_cnt_q == 4'd15) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign sclk_o  = sclk_q;
    assign done_o  = done_q;
    assign frame_o = shift_q;

endmodule

// File: rtl/temp_sensor_sampler.sv
// Periodic SPI temperature read, clamp to 0..99 degC, optional 4-tap moving average.
// Latency: temp_valid 34*CLK_DIV+2 cycles after WAIT exits (cs_n falling).
// Backpressure: none; temp_valid is a one-cycle strobe, temperature holds until the next one.
// Ports: clk, rst (async active-low), enable, miso -> sclk, cs_n, temperature[7:0], temp_valid, sensor_fault.
module temp_sensor_sampler
    import thermo_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int AVG_EN        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       miso,
    output logic       sclk,
    output logic       cs_n,
    output logic [7:0] temperature,
    output logic       temp_valid,
    output logic       sensor_fault
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cs_n_q;
    logic [15:0]      frame_q;
    logic [7:0]       temp_q;
    logic             valid_q;
    logic             fault_q;
    logic [6:0]       hist_q [4];
    logic             hist_vld_q;

    logic             rx_start;
    logic             rx_done;
    logic [15:0]      rx_frame;

    logic [6:0]       samp;
    logic [6:0]       hist_d [4];
    logic [8:0]       sum;
    logic [7:0]       temp_d;

    // Kick the receiver on the last setup cycle so the first sclk half-period
    // starts exactly when SHIFT is entered.
    assign rx_start = (state_q == ST_CS_SETUP) && (cnt_q == DIV_LAST);

    sensor_spi_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .start_i (rx_start),
        .miso_i  (miso),
        .sclk_o  (sclk),
        .done_o  (rx_done),
        .frame_o (rx_frame)
    );

    always_comb begin
        samp = clamp_deg(frame_q[15:8]);
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (!hist_vld_q) begin
            // First good sample after reset fills the whole window.
            for (int i = 0; i < 4; i++) begin
                hist_d[i] = samp;
            end
        end else begin
            hist_d[0] = hist_q[1];
            hist_d[1] = hist_q[2];
            hist_d[2] = hist_q[3];
            hist_d[3] = samp;
        end
        sum = 9'(hist_d[0]) + 9'(hist_d[1]) + 9'(hist_d[2]) + 9'(hist_d[3]);
        if (AVG_EN != 0) begin
            temp_d = 8'(sum >> 2);
        end else begin
            temp_d = {1'b0, samp};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cs_n_q     <= 1'b1;
            frame_q    <= '0;
            temp_q     <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            hist_q     <= '{default: '0};
            hist_vld_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == PERIOD_LAST) begin
                        state_q <= ST_CS_SETUP;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CS_SETUP: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (rx_done) begin
                        frame_q <= rx_frame;
                        state_q <= ST_CS_HOLD;
                    end
                end
                ST_CS_HOLD: begin
                    if (cnt_q == DIV_LAST) begin
                        cs_n_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_PROCESS;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PROCESS: begin
                    state_q <= ST_UPDATE;
                    if (frame_q == FAULT_FRAME) begin
                        // All-ones means the sensor is absent or broken; keep the old reading.
                        fault_q <= 1'b1;
                    end else begin
                        fault_q    <= 1'b0;
                        hist_q     <= hist_d;
                        hist_vld_q <= 1'b1;
                        temp_q     <= temp_d;
                        valid_q    <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (enable) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cs_n         = cs_n_q;
    assign temperature  = temp_q;
    assign temp_valid   = valid_q;
    assign sensor_fault = fault_q;

endmodule

// File: tb/tb_temp_sensor_sampler.sv
// Bench for temp_sensor_sampler: averaging and pass-through instances in lockstep, SPI sensor model.
// Latency: checked per frame against the cs_n falling edge.
// Backpressure: n/a.
module tb_temp_sensor_sampler;

    localparam int CD     = 2;
    localparam int SP     = 100;
    localparam int T_CSHI = 34 * CD + 1;
    localparam int T_VLD  = 34 * CD + 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       enable = 1'b0;
    logic       miso   = 1'b0;
    logic       sclk, cs_n, temp_valid, sensor_fault;
    logic [7:0] temperature;
    logic       raw_sclk, raw_cs_n, raw_temp_valid, raw_fault;
    logic [7:0] raw_temperature;

    temp_sensor_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_EN(1)) u_avg (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .miso         (miso),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .temperature  (temperature),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault)
    );

    temp_sensor_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_EN(0)) u_raw (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .miso         (miso),
        .sclk         (raw_sclk),
        .cs_n         (raw_cs_n),
        .temperature  (raw_temperature),
        .temp_valid   (raw_temp_valid),
        .sensor_fault (raw_fault)
    );

    always #5 clk = ~clk;

    // Sensor: presents the MSB when selected, advances on each sclk fall.
    logic [15:0] sens_frame = 16'h0;
    logic [15:0] sens_sh    = 16'h0;
    bit          in_frame   = 1'b0;
    always @(cs_n or negedge sclk) begin
        if (cs_n) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            sens_sh  = sens_frame;
            miso     = sens_sh[15];
        end else begin
            sens_sh = {sens_sh[14:0], 1'b0};
            miso    = sens_sh[15];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: window of clamped degrees, average = floor(sum/4).
    int hist[$];
    int exp_temp  = 0;
    int exp_raw   = 0;
    int exp_fault = 0;

    function automatic int deg_of(input logic [15:0] f);
        int v;
        int d;
        v = int'($signed(f[15:4]));
        if (v >= 0) d = v / 16;
        else        d = -((-v + 15) / 16);
        if (d < 0)  d = 0;
        if (d > 99) d = 99;
        return d;
    endfunction

    task automatic model_frame(input logic [15:0] f);
        int c;
        int s;
        if (f == 16'hFFFF) begin
            exp_fault = 1;
        end else begin
            exp_fault = 0;
            c = deg_of(f);
            if (hist.size() == 0) begin
                repeat (4) hist.push_back(c);
            end else begin
                hist.push_back(c);
                void'(hist.pop_front());
            end
            s = 0;
            foreach (hist[i]) s += hist[i];
            exp_temp = s / 4;
            exp_raw  = c;
        end
    endtask

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        case ($urandom_range(0, 3))
            0:       f = 16'hFFFF;
            1:       f = 16'($urandom_range(0, 65535));
            default: f = {12'($urandom_range(0, 1700)), 4'($urandom_range(0, 15))};
        endcase
        return f;
    endfunction

    // mode 0: plain frame, 1: drop enable at bit 8, 2: reset at bit 8
    task automatic do_frame(input logic [15:0] f, input int mode);
        int   n, rises, nv, nvr, tv, first_hi, diff, idle_cs;
        logic prev;
        sens_frame = f;
        n = 0;
        while (cs_n !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            chk("cs_fall_timeout", n, 0);
            return;
        end
        rises = 0; nv = 0; nvr = 0; tv = -1; first_hi = -1; diff = 0; prev = 1'b0;
        for (int t = 0; t < T_VLD + 4; t++) begin
            if (sclk && !prev && !cs_n) rises++;
            prev = sclk;
            if (temp_valid) begin
                nv++;
                tv = t;
            end
            if (raw_temp_valid) nvr++;
            if (cs_n && first_hi < 0) first_hi = t;
            if (raw_cs_n !== cs_n || raw_sclk !== sclk) diff++;
            if (mode == 1 && rises == 8) enable = 1'b0;
            if (mode == 2 && rises == 8) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_cs_n", cs_n, 1);
                chk("rst_sclk", sclk, 0);
                chk("rst_temp", temperature, 0);
                chk("rst_valid", temp_valid, 0);
                chk("rst_fault", sensor_fault, 0);
                chk("rst_raw_temp", raw_temperature, 0);
                hist.delete();
                exp_temp = 0; exp_raw = 0; exp_fault = 0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
        end
        model_frame(f);
        chk("sclk_rises", rises, 16);
        chk("cs_n_release", first_hi, T_CSHI);
        chk("valid_pulses", nv, (f == 16'hFFFF) ? 0 : 1);
        chk("raw_valid_pulses", nvr, (f == 16'hFFFF) ? 0 : 1);
        if (f != 16'hFFFF) chk("valid_latency", tv, T_VLD);
        chk("temperature", temperature, exp_temp);
        chk("raw_temperature", raw_temperature, exp_raw);
        chk("fault", sensor_fault, exp_fault);
        chk("raw_fault", raw_fault, exp_fault);
        chk("lockstep", diff, 0);
        if (mode == 1) begin
            idle_cs = 0;
            repeat (3 * SP) begin
                @(negedge clk);
                if (!cs_n) idle_cs++;
            end
            chk("idle_no_cs", idle_cs, 0);
            enable = 1'b1;
        end
    endtask

    initial begin
        #12;
        chk("init_cs_n", cs_n, 1);
        chk("init_sclk", sclk, 0);
        chk("init_temp", temperature, 0);
        chk("init_valid", temp_valid, 0);
        chk("init_fault", sensor_fault, 0);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;

        do_frame(16'h1900, 0);   // 25, preload
        do_frame(16'h2500, 0);   // 37 -> 28
        do_frame(16'h3000, 0);   // 48 -> 33
        do_frame(16'h3B00, 0);   // 59 -> 42
        do_frame(16'hF600, 0);   // -10 clamps to 0
        do_frame(16'h7800, 0);   // 120 clamps to 99
        do_frame(16'hFFFF, 0);   // fault, no update
        do_frame(16'h4000, 0);   // 64, fault clears
        do_frame(16'hFFFF, 0);   // fault set again before reset
        do_frame(16'h2A30, 2);   // reset mid-frame
        do_frame(16'h1230, 0);   // full frame after reset, preload
        do_frame(rand_frame(), 1);
        for (int i = 0; i < 12; i++) begin
            do_frame(rand_frame(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/temp_sensor_sampler.md
Name: temp_sensor_sampler

Overview:
Upstream front-end for digital_thermometer. Periodically reads a 16-bit SPI temperature sensor (read-only, mode 0), converts the reading to whole degrees C, clamps it to 0..99, and applies a 4-sample moving average. It presents a stable 8-bit temperature plus a one-cycle update strobe. Its temperature output connects directly to the thermometer display's temperature input.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (>=1)
SAMPLE_PERIOD, 1000, clk cycles between conversion starts (> frame length)
AVG_EN, 1, 1 = 4-sample moving average, 0 = pass the clamped sample through

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
enable  input  1  level; 1 = periodic sampling runs
miso  input  1  sensor serial data
sclk  output  1  serial clock, idles low
cs_n  output  1  sensor chip select, active-low
temperature  output  8  averaged, clamped temperature in degC (0..99)
temp_valid  output  1  one-cycle pulse when temperature updates
sensor_fault  output  1  sticky until the next good frame; last frame was 0xFFFF

Behaviour:
- Reset (rst=0, async): sclk=0, cs_n=1, temperature=0, temp_valid=0, sensor_fault=0, history empty, period counter=0, FSM=IDLE. A reset mid-frame aborts the frame immediately. The partial frame is discarded.
- FSM states: IDLE -> WAIT -> CS_SETUP -> SHIFT -> CS_HOLD -> PROCESS -> UPDATE -> WAIT. If enable=0 at the end of UPDATE, the FSM goes to IDLE instead of WAIT.
- IDLE -> WAIT when enable=1. The period counter resets to 0 on entry to WAIT.
- WAIT: the counter counts while enable=1. At SAMPLE_PERIOD-1 the FSM goes to CS_SETUP. enable=0 in WAIT returns the FSM to IDLE.
- CS_SETUP: cs_n=0 for CLK_DIV cycles with sclk low.
- SHIFT: sclk toggles every CLK_DIV cycles, giving 16 rising edges.
  - miso is sampled into the shift register in the cycle sclk goes high, MSB first.
  - The FSM leaves SHIFT after the 16th falling edge, with sclk=0.
- enable=0 during CS_SETUP or SHIFT does not abort the frame.
- CS_HOLD: cs_n=0 for CLK_DIV cycles, then cs_n=1.
- Frame format: bits[15:4] = signed 12-bit temperature in 1/16 degC; bits[3:0] are ignored.
- PROCESS:
  - If frame==16'hFFFF: sensor_fault=1, history and temperature unchanged, no temp_valid.
  - Otherwise: integer degC = arithmetic shift right by 4 of bits[15:4] (truncates toward minus infinity). Clamp to 0 if negative and to 99 if above 99. sensor_fault=0.
- Averaging (AVG_EN=1):
  - 4-entry history of clamped values.
  - The first good sample after reset preloads all 4 entries.
  - Each later sample shifts in and drops the oldest.
  - Result = sum of the 4 entries >> 2, truncated. The sum is 9 bits wide (max 396).
- UPDATE: temperature is registered. temp_valid=1 for exactly this one cycle, and only for good frames.
- Latency: temp_valid occurs 1 cycle after PROCESS, i.e. (2+32+1)*CLK_DIV... precisely: CS_SETUP CLK_DIV + 32*CLK_DIV + CS_HOLD CLK_DIV + 2 cycles after WAIT exits.
- temperature is held constant between temp_valid pulses.
- cs_n never toggles during SHIFT.

Decomposition:
- Shared include/package thermo_pkg: TEMP_MAX=99, FRAME_BITS=16, FAULT_FRAME=16'hFFFF, FSM state encodings.
- One natural sub-module: sensor_spi_rx. It holds the sclk divider, the bit counter and the shift register, with a start/done handshake. done is a 1-cycle pulse carrying the 16-bit frame.
- The top level holds the period counter, FSM, clamp and averager.

Test Plan:
(Bench uses CLK_DIV=2, SAMPLE_PERIOD=100 and a behavioural sensor model.)
1. Reset check: assert rst=0 mid-run -> cs_n=1, sclk=0, temperature=0, temp_valid=0, sensor_fault=0 asynchronously, before the next clk edge.
2. Single read: sensor returns 16'h1900 (25.0 degC) -> exactly 16 sclk rising edges inside cs_n low, one temp_valid pulse, temperature=25 (preload).
3. Averaging: successive frames 25, 37, 48, 59 (16'h2500, 16'h3000, 16'h3B00 after 16'h1900) -> temperature 25, 28, 33, 42.
4. Clamp: frame 16'hF600 (-10 degC) -> history value 0; frame 16'h7800 (120 degC) -> 99. With AVG_EN=0 these give temperature=0 and temperature=99 directly.
5. Fault: frame 16'hFFFF -> sensor_fault=1, no temp_valid, temperature unchanged. Next frame 16'h4000 (64 degC) -> sensor_fault=0 and temp_valid pulses.
6. Mid-frame events:
   - enable=0 at bit 8 -> frame completes and updates, then cs_n stays 1 (IDLE).
   - rst=0 at bit 8 -> abort; after release, the next frame is a full 16 bits and preloads history.
